// File: rtl/aes_dec_defs.sv
// Shared definitions for the AES-128 decryption path: block width, round count
// and the sequencer state encoding.
package aes_dec_defs;

    localparam int AES_BLOCK_W = 128;
    localparam int AES128_NR   = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_KEY_WAIT = 2'd1,
        ST_DONE     = 2'd2
    } seq_state_e;

endpackage

// File: rtl/aes_inv_round_sequencer.sv
// Iterative AES-128 decryption controller: owns the state register and round
// counter, fetches round keys NR..0 and steps the external inverse-round datapath.
module aes_inv_round_sequencer
    import aes_dec_defs::*;
#(
    parameter int NR        = AES128_NR,
    parameter int KEY_IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   key_req,
    output logic [KEY_IDX_W-1:0]   key_idx,
    input  logic                   key_valid,
    input  logic [AES_BLOCK_W-1:0] key_data,
    output logic [AES_BLOCK_W-1:0] dp_state,
    output logic [AES_BLOCK_W-1:0] dp_key,
    output logic                   dp_last_round,
    input  logic [AES_BLOCK_W-1:0] dp_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    input  logic                   abort,
    output logic                   busy
);

    localparam logic [KEY_IDX_W-1:0] NR_IDX = KEY_IDX_W'(NR);

    seq_state_e             state;
    logic [AES_BLOCK_W-1:0] state_reg;
    logic [KEY_IDX_W-1:0]   round_cnt;

    assign dp_state      = state_reg;
    assign out_data      = state_reg;
    assign dp_key        = key_data;
    assign dp_last_round = (state == ST_KEY_WAIT) && (round_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            state_reg <= '0;
            round_cnt <= '0;
            in_ready  <= 1'b1;
            key_req   <= 1'b0;
            key_idx   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= in_data;
                        round_cnt <= NR_IDX;
                        key_idx   <= NR_IDX;
                        key_req   <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_KEY_WAIT;
                    end
                end
                ST_KEY_WAIT: begin
                    // abort beats a coincident key_valid: state_reg is left untouched
                    if (abort) begin
                        key_req  <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (key_valid) begin
                        if (round_cnt == NR_IDX) begin
                            // first key is a bare AddRoundKey; datapath result unused
                            state_reg <= state_reg ^ key_data;
                            round_cnt <= NR_IDX - 1'b1;
                            key_idx   <= NR_IDX - 1'b1;
                        end else if (round_cnt != '0) begin
                            state_reg <= dp_result;
                            round_cnt <= round_cnt - 1'b1;
                            key_idx   <= round_cnt - 1'b1;
                        end else begin
                            state_reg <= dp_result;
                            key_req   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort || out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    key_req   <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
